// File: rtl/config_pkg.sv
// Core-wide configuration constants.
package config_pkg;

    localparam int DMemAddrWidth = 12;

endpackage

// File: rtl/mem_pkg.sv
// Data memory access types shared by the LSU, arbiter and memory.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CORE = 2'd1,
        OWNER_DMA  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating DMA stall counter; raises boost after MaxWait stalled cycles.
module arb_wait_counter #(
    parameter int MaxWait = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_req,
    input  logic dma_ack,
    output logic boost
);

    localparam int CntW = $clog2(MaxWait + 1);

    logic [CntW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!dma_req || dma_ack) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CntW'(MaxWait)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign boost = (wait_cnt == CntW'(MaxWait));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between core LSU and DMA/debug requester.
// Define DMEM_ARB_FAIR_EN for starvation-free DMA (boost after MaxWait stalls).
module dmem_arbiter
    import config_pkg::*;
    import mem_pkg::*;
#(
    parameter int MaxWait = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_req,
    input  logic                     core_we,
    input  mem_width_t               core_width,
    input  logic                     core_sign_extend,
    input  logic [DMemAddrWidth-1:0] core_addr,
    input  logic [31:0]              core_wdata,
    output logic                     core_ack,
    output logic [31:0]              core_rdata,
    output logic                     core_err,
    input  logic                     dma_req,
    input  logic                     dma_we,
    input  mem_width_t               dma_width,
    input  logic                     dma_sign_extend,
    input  logic [DMemAddrWidth-1:0] dma_addr,
    input  logic [31:0]              dma_wdata,
    output logic                     dma_ack,
    output logic                     dma_rvalid,
    output logic [31:0]              dma_rdata,
    output logic                     dma_err,
    output logic                     mem_write_enable,
    output mem_width_t               mem_width,
    output logic                     mem_sign_extend,
    output logic [DMemAddrWidth-1:0] mem_address,
    output logic [31:0]              mem_data_in,
    input  logic [31:0]              mem_data_out,
    input  logic                     mem_alignment_error
);

    if (MaxWait < 1 || MaxWait > 15) begin : g_bad_max_wait
        $error("dmem_arbiter: MaxWait must be in 1..15");
    end

    arb_owner_t owner;
    logic       boost;
    logic       owner_we;

`ifdef DMEM_ARB_FAIR_EN
    arb_wait_counter #(
        .MaxWait(MaxWait)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .dma_req(dma_req),
        .dma_ack(dma_ack),
        .boost  (boost)
    );
`else
    assign boost = 1'b0;
`endif

    // Nothing is granted while reset is held, so no write can slip through.
    always_comb begin
        owner = OWNER_NONE;
        if (!reset) begin
            owner = OWNER_NONE;
        end else if (boost && dma_req) begin
            owner = OWNER_DMA;
        end else if (core_req) begin
            owner = OWNER_CORE;
        end else if (dma_req) begin
            owner = OWNER_DMA;
        end
    end

    assign core_ack = (owner == OWNER_CORE);
    assign dma_ack  = (owner == OWNER_DMA);

    always_comb begin
        mem_width       = core_width;
        mem_sign_extend = core_sign_extend;
        mem_address     = core_addr;
        mem_data_in     = core_wdata;
        owner_we        = core_ack & core_we;
        if (dma_ack) begin
            mem_width       = dma_width;
            mem_sign_extend = dma_sign_extend;
            mem_address     = dma_addr;
            mem_data_in     = dma_wdata;
            owner_we        = dma_we;
        end
    end

    assign mem_write_enable = owner_we & ~mem_alignment_error;

    assign core_rdata = core_ack ? mem_data_out : 32'h0;
    assign core_err   = core_ack & mem_alignment_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= 32'h0;
            dma_err    <= 1'b0;
        end else begin
            dma_rvalid <= dma_ack;
            if (dma_ack) begin
                dma_rdata <= mem_data_out;
                dma_err   <= mem_alignment_error;
            end
        end
    end

endmodule
